// File: rtl/pc_unit.sv
// Program counter / next-PC stage with exception state (EPC, cause) and retired-instruction counter.
// One-cycle latency: pc updates on the rising edge after inputs are presented; stall_i freezes all state.
module pc_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
   parameter int          COUNT_W    = 32
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               stall_i,
   input  logic               halt_i,
   input  logic               branch_i,
   input  logic [15:0]        branch_offset_i,
   input  logic               alu_zero_i,
   input  logic               jump_i,
   input  logic [25:0]        jump_target_i,
   input  logic               jump_reg_i,
   input  logic [31:0]        reg_target_i,
   input  logic               chk_ovf_add_i,
   input  logic               chk_ovf_sub_i,
   input  logic               overflow_add_i,
   input  logic               overflow_sub_i,
   input  logic               eret_i,
   output logic [31:0]        pc_o,
   output logic [31:0]        pc_plus4_o,
   output logic [31:0]        epc_o,
   output logic [1:0]         cause_o,
   output logic               halted_o,
   output logic [COUNT_W-1:0] instr_count_o
);

   typedef enum logic {
      ST_RUN,
      ST_HALTED
   } state_e;

   state_e               state_q, state_d;
   logic [31:0]          pc_q, pc_d;
   logic [31:0]          epc_q, epc_d;
   logic [1:0]           cause_q, cause_d;
   logic [COUNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]          pc_plus4;
   logic [31:0]          br_off;
   logic [1:0]           exc_cause;

   assign pc_plus4 = pc_q + 32'd4;
   assign br_off   = {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      epc_d     = epc_q;
      cause_d   = cause_q;
      cnt_d     = cnt_q;
      exc_cause = 2'b00;

      if (state_q == ST_RUN && !stall_i) begin
         cnt_d = cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};

         if (chk_ovf_add_i && overflow_add_i) begin
            exc_cause = 2'b01;
         end else if (chk_ovf_sub_i && overflow_sub_i) begin
            exc_cause = 2'b10;
         end else if (jump_reg_i && (reg_target_i[1:0] != 2'b00)) begin
            exc_cause = 2'b11;
         end

         // An exception outranks halt and every control-flow request.
         if (exc_cause != 2'b00) begin
            epc_d   = pc_q;
            pc_d    = EXC_VECTOR;
            cause_d = exc_cause;
         end else if (halt_i) begin
            state_d = ST_HALTED;
         end else if (eret_i) begin
            pc_d    = epc_q;
            cause_d = 2'b00;
         end else if (jump_reg_i) begin
            pc_d = reg_target_i;
         end else if (jump_i) begin
            pc_d = {pc_plus4[31:28], jump_target_i, 2'b00};
         end else if (branch_i && !alu_zero_i) begin
            pc_d = pc_plus4 + br_off;
         end else begin
            pc_d = pc_plus4;
         end
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         epc_q   <= 32'h0000_0000;
         cause_q <= 2'b00;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_o          = pc_q;
   assign pc_plus4_o    = pc_plus4;
   assign epc_o         = epc_q;
   assign cause_o       = cause_q;
   assign halted_o      = (state_q == ST_HALTED);
   assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: expected state pushed per step, popped and checked after the clock edge.
module tb_pc_unit;

   logic        clock_i = 1'b0;
   logic        reset_i;
   logic        stall_i, halt_i, branch_i, alu_zero_i, jump_i, jump_reg_i;
   logic [15:0] branch_offset_i;
   logic [25:0] jump_target_i;
   logic [31:0] reg_target_i;
   logic        chk_ovf_add_i, chk_ovf_sub_i, overflow_add_i, overflow_sub_i, eret_i;
   logic [31:0] pc_o, pc_plus4_o, epc_o;
   logic [1:0]  cause_o;
   logic        halted_o;
   logic [31:0] instr_count_o;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic [31:0] epc;
      logic [1:0]  cause;
      logic        halted;
      logic [31:0] cnt;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   errors  = 0;

   pc_unit dut (
      .clock_i(clock_i), .reset_i(reset_i), .stall_i(stall_i), .halt_i(halt_i),
      .branch_i(branch_i), .branch_offset_i(branch_offset_i), .alu_zero_i(alu_zero_i),
      .jump_i(jump_i), .jump_target_i(jump_target_i), .jump_reg_i(jump_reg_i),
      .reg_target_i(reg_target_i), .chk_ovf_add_i(chk_ovf_add_i), .chk_ovf_sub_i(chk_ovf_sub_i),
      .overflow_add_i(overflow_add_i), .overflow_sub_i(overflow_sub_i), .eret_i(eret_i),
      .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .epc_o(epc_o), .cause_o(cause_o),
      .halted_o(halted_o), .instr_count_o(instr_count_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic clr();
      stall_i = 0; halt_i = 0; branch_i = 0; branch_offset_i = '0; alu_zero_i = 0;
      jump_i = 0; jump_target_i = '0; jump_reg_i = 0; reg_target_i = '0;
      chk_ovf_add_i = 0; chk_ovf_sub_i = 0; overflow_add_i = 0; overflow_sub_i = 0; eret_i = 0;
   endtask

   task automatic expect_st(string tag, logic [31:0] pc, logic [31:0] epc, logic [1:0] cause,
                            logic halted, logic [31:0] cnt);
      exp_t e;
      e.tag = tag; e.pc = pc; e.epc = epc; e.cause = cause; e.halted = halted; e.cnt = cnt;
      q.push_back(e);
   endtask

   task automatic chk(string tag, string fld, logic [31:0] got, logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s.%s got %h expected %h", tag, fld, got, exp);
      end
   endtask

   task automatic compare_now();
      exp_t e;
      if (q.size() == 0) begin
         vectors++;
         errors++;
         $error("FAIL scoreboard empty got 0 entries expected 1");
      end else begin
         e = q.pop_front();
         chk(e.tag, "pc",       pc_o,                    e.pc);
         chk(e.tag, "pc_plus4", pc_plus4_o,              e.pc + 32'd4);
         chk(e.tag, "epc",      epc_o,                   e.epc);
         chk(e.tag, "cause",    {30'd0, cause_o},        {30'd0, e.cause});
         chk(e.tag, "halted",   {31'd0, halted_o},       {31'd0, e.halted});
         chk(e.tag, "count",    instr_count_o,           e.cnt);
      end
   endtask

   task automatic tick();
      @(posedge clock_i);
      #1;
      compare_now();
      clr();
   endtask

   task automatic jr(logic [31:0] tgt);
      jump_reg_i = 1; reg_target_i = tgt;
   endtask

   initial begin
      clr();
      reset_i = 1'b0;
      #2;
      expect_st("reset", 32'h0, 32'h0, 2'b00, 0, 0);
      compare_now();
      @(negedge clock_i);
      reset_i = 1'b1;

      expect_st("seq1", 32'h4, 0, 0, 0, 1); tick();
      expect_st("seq2", 32'h8, 0, 0, 0, 2); tick();
      expect_st("seq3", 32'hC, 0, 0, 0, 3); tick();

      jr(32'h100);                                        expect_st("jr100", 32'h100, 0, 0, 0, 4); tick();
      branch_i = 1; branch_offset_i = 16'hFFFE;           expect_st("br_taken", 32'h0FC, 0, 0, 0, 5); tick();
      jr(32'h100);                                        expect_st("jr100b", 32'h100, 0, 0, 0, 6); tick();
      branch_i = 1; branch_offset_i = 16'hFFFE; alu_zero_i = 1;
                                                          expect_st("br_not", 32'h104, 0, 0, 0, 7); tick();

      jr(32'h40);                                         expect_st("jr40", 32'h40, 0, 0, 0, 8); tick();
      chk_ovf_add_i = 1; overflow_add_i = 1; jump_i = 1; jump_target_i = 26'h123;
                                                          expect_st("exc_add", 32'h80, 32'h40, 2'b01, 0, 9); tick();
      eret_i = 1;                                         expect_st("eret1", 32'h40, 32'h40, 2'b00, 0, 10); tick();

      jr(32'h200);                                        expect_st("jr200", 32'h200, 32'h40, 0, 0, 11); tick();
      jr(32'h302);                                        expect_st("exc_mis", 32'h80, 32'h200, 2'b11, 0, 12); tick();
      jr(32'h200);                                        expect_st("sticky", 32'h200, 32'h200, 2'b11, 0, 13); tick();
      jr(32'h300);                                        expect_st("jr300", 32'h300, 32'h200, 2'b11, 0, 14); tick();
      chk_ovf_sub_i = 1; overflow_sub_i = 1;              expect_st("exc_sub", 32'h80, 32'h300, 2'b10, 0, 15); tick();
      chk_ovf_add_i = 1; overflow_add_i = 1; chk_ovf_sub_i = 1; overflow_sub_i = 1;
                                                          expect_st("exc_prio", 32'h80, 32'h80, 2'b01, 0, 16); tick();
      eret_i = 1;                                         expect_st("eret2", 32'h80, 32'h80, 2'b00, 0, 17); tick();
      overflow_add_i = 1; overflow_sub_i = 1;             expect_st("no_chk", 32'h84, 32'h80, 2'b00, 0, 18); tick();

      jr(32'hFFFF_FFFC);                                  expect_st("jr_top", 32'hFFFF_FFFC, 32'h80, 0, 0, 19); tick();
      expect_st("wrap", 32'h0, 32'h80, 0, 0, 20); tick();
      jr(32'h8FFF_FFFC);                                  expect_st("jr_8f", 32'h8FFF_FFFC, 32'h80, 0, 0, 21); tick();
      jump_i = 1; jump_target_i = 26'h0;                  expect_st("j_region", 32'h9000_0000, 32'h80, 0, 0, 22); tick();
      jump_i = 1; jump_target_i = 26'h10; branch_i = 1; branch_offset_i = 16'h0004;
                                                          expect_st("j_vs_br", 32'h9000_0040, 32'h80, 0, 0, 23); tick();
      halt_i = 1; chk_ovf_add_i = 1; overflow_add_i = 1;  expect_st("halt_exc", 32'h80, 32'h9000_0040, 2'b01, 0, 24); tick();

      jr(32'h10);                                         expect_st("jr10", 32'h10, 32'h9000_0040, 2'b01, 0, 25); tick();
      for (int i = 0; i < 3; i++) begin
         stall_i = 1; halt_i = 1; chk_ovf_add_i = 1; overflow_add_i = 1;
         expect_st("stall", 32'h10, 32'h9000_0040, 2'b01, 0, 25); tick();
      end
      halt_i = 1;                                         expect_st("halt", 32'h10, 32'h9000_0040, 2'b01, 1, 26); tick();
      for (int i = 0; i < 5; i++) begin
         jump_i = 1; jump_target_i = 26'h3FF; eret_i = (i == 2); chk_ovf_sub_i = 1; overflow_sub_i = 1;
         jr(32'h555);
         expect_st("frozen", 32'h10, 32'h9000_0040, 2'b01, 1, 26); tick();
      end

      #3;
      reset_i = 1'b0;
      #1;
      expect_st("async_rst", 32'h0, 32'h0, 2'b00, 0, 0);
      compare_now();
      @(negedge clock_i);
      reset_i = 1'b1;
      expect_st("post_rst", 32'h4, 32'h0, 2'b00, 0, 1); tick();

      if (q.size() != 0) begin
         vectors++;
         errors++;
         $error("FAIL scoreboard leftover got %0d entries expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
